// File: rtl/apb_pkg.sv
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared APB master state encoding and peripheral register map.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    // Sin-LUT slave register offsets
    localparam logic [7:0]  SIN_CTRL_ADDR = 8'h10;
    localparam logic [7:0]  SIN_OUT_ADDR  = 8'h14;

    localparam logic [31:0] APB_ERR_DATA  = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ============================================================================
// Module   : apb_wait_timer
// Brief    : Saturating wait-state counter with clear, enable and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != {c_CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_watchdog
            assign tc = 1'b0;
        end else begin : g_watchdog
            assign tc = (r_count == c_CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_master_ctrl.sv
// ============================================================================
// Module   : apb_master_ctrl
// Brief    : Single-outstanding command to APB3 requester with wait watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    localparam logic [1:0] c_ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] c_ST_SETUP  = 2'(SETUP);
    localparam logic [1:0] c_ST_ACCESS = 2'(ACCESS);
    localparam logic [1:0] c_ST_RESP   = 2'(RESP);

    logic [1:0] r_state;
    logic       w_timer_clr;
    logic       w_timer_en;
    logic       w_timeout;

    assign cmd_ready   = (r_state == c_ST_IDLE);
    assign w_timer_clr = (r_state == c_ST_SETUP);
    assign w_timer_en  = (r_state == c_ST_ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clr     (w_timer_clr),
        .en      (w_timer_en),
        .tc      (w_timeout)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= c_ST_IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        paddr   <= cmd_addr;
                        pwrite  <= cmd_write;
                        pwdata  <= cmd_write ? cmd_wdata : '0;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    penable <= 1'b1;
                    r_state <= c_ST_ACCESS;
                end
                c_ST_ACCESS: begin
                    // Slave completion takes priority over a same-cycle watchdog hit
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        r_state     <= c_ST_RESP;
                    end else if (w_timeout) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        r_state     <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
// ============================================================================
// Module   : tb_apb_master_ctrl
// Brief    : Directed self-checking bench with a configurable sin-LUT slave model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_ctrl;
    import apb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    apb_master_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Slave model: s_waits wait states before pready, s_hang never completes
    int          s_waits = 0;
    bit          s_hang  = 1'b0;
    logic [7:0]  s_wcnt  = '0;
    logic [31:0] s_ctrl  = '0;
    logic        s_hit_ctrl;
    logic        s_hit_out;

    assign s_hit_ctrl = (paddr == {24'h0, SIN_CTRL_ADDR});
    assign s_hit_out  = (paddr == {24'h0, SIN_OUT_ADDR});
    assign pready     = psel && penable && !s_hang && (s_wcnt == 8'(s_waits));
    assign pslverr    = pready && !(s_hit_ctrl || s_hit_out);
    assign prdata     = s_hit_ctrl ? s_ctrl : (s_hit_out ? (s_ctrl << 15) : 32'h0);

    always @(posedge pclk) begin
        if (psel && penable && !pready) s_wcnt <= s_wcnt + 8'd1;
        else                            s_wcnt <= 8'd0;
        if (psel && penable && pready && pwrite && s_hit_ctrl) s_ctrl <= pwdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    int          r_lat, r_nrsp, r_acc;
    logic [31:0] r_rdata;
    logic        r_err, r_to, r_stable, r_psel1, r_pen1, r_pen2, r_rdy_after;

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        int acc;
        int k;
        int post;
        bit seen;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge pclk);
        if (!cmd_ready) check("ready_wait", 32'(cmd_ready), 32'd1);
        @(posedge pclk);
        #1;
        acc = cyc;
        // Scramble command inputs after accept; the transfer must not see them
        cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 32'hFFFF_FFF0; cmd_wdata = 32'hA5A5_A5A5;
        r_lat = -1; r_nrsp = 0; r_acc = 0; r_stable = 1'b1; r_rdy_after = 1'b0;
        r_psel1 = 1'b0; r_pen1 = 1'b1; r_pen2 = 1'b0;
        r_rdata = 32'hX; r_err = 1'bx; r_to = 1'bx;
        seen = 1'b0; post = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            k = cyc - acc;
            if (k == 0) begin r_psel1 = psel; r_pen1 = penable; end
            if (k == 1) r_pen2 = penable;
            if (psel && penable) begin
                r_acc++;
                if (paddr !== a || pwdata !== (w ? d : 32'h0) || pwrite !== w) r_stable = 1'b0;
            end
            if (rsp_valid) begin
                r_nrsp++;
                if (!seen) begin
                    seen = 1'b1; r_lat = k;
                    r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
                end
            end else if (seen) begin
                if (post == 0) r_rdy_after = cmd_ready;
                post++;
                if (post == 3) break;
            end
        end
    endtask

    int n_rst_rsp;

    initial begin
        // Reset state
        repeat (3) @(negedge pclk);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rsp", {28'h0, rsp_valid, rsp_err, rsp_timeout, 1'b0}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        presetn = 1'b1;

        // Zero-wait write to ctrl
        s_waits = 0;
        run_cmd(1'b1, 32'h10, 32'h2);
        check("t1_psel_n1", 32'(r_psel1), 32'd1);
        check("t1_pen_n1", 32'(r_pen1), 32'd0);
        check("t1_pen_n2", 32'(r_pen2), 32'd1);
        check("t1_lat", 32'(r_lat), 32'd2);
        check("t1_nrsp", 32'(r_nrsp), 32'd1);
        check("t1_err", 32'(r_err), 32'd0);
        check("t1_rdata", r_rdata, 32'h0);
        check("t1_slave_ctrl", s_ctrl, 32'h2);

        // Registered-pready read of result
        s_waits = 1;
        run_cmd(1'b0, 32'h14, 32'h1234_5678);
        check("t2_lat", 32'(r_lat), 32'd3);
        check("t2_rdata", r_rdata, 32'h0001_0000);
        check("t2_err", 32'(r_err), 32'd0);
        check("t2_pwdata_stable", 32'(r_stable), 32'd1);

        // Unmapped address: slave error
        run_cmd(1'b0, 32'h20, 32'h0);
        check("t3_err", 32'(r_err), 32'd1);
        check("t3_timeout", 32'(r_to), 32'd0);
        check("t3_rdata", r_rdata, 32'h0);

        // Zero-wait readback of ctrl
        s_waits = 0;
        run_cmd(1'b0, 32'h10, 32'h0);
        check("t3b_rdata", r_rdata, 32'h2);
        check("t3b_lat", 32'(r_lat), 32'd2);

        // Five wait states
        s_waits = 5;
        run_cmd(1'b1, 32'h10, 32'h33);
        check("t4_access_cycles", 32'(r_acc), 32'd6);
        check("t4_stable", 32'(r_stable), 32'd1);
        check("t4_nrsp", 32'(r_nrsp), 32'd1);
        check("t4_lat", 32'(r_lat), 32'd7);
        check("t4_slave_ctrl", s_ctrl, 32'h33);

        // Watchdog abort
        s_hang = 1'b1;
        run_cmd(1'b0, 32'h14, 32'h0);
        check("t5_access_cycles", 32'(r_acc), 32'd16);
        check("t5_lat", 32'(r_lat), 32'd17);
        check("t5_err", 32'(r_err), 32'd1);
        check("t5_timeout", 32'(r_to), 32'd1);
        check("t5_rdata", r_rdata, 32'h0);
        check("t5_ready_after", 32'(r_rdy_after), 32'd1);
        check("t5_nrsp", 32'(r_nrsp), 32'd1);

        // Normal read after abort clears the timeout flag
        s_hang = 1'b0; s_waits = 0;
        run_cmd(1'b0, 32'h14, 32'h0);
        check("t5b_rdata", r_rdata, 32'h0019_8000);
        check("t5b_timeout", 32'(r_to), 32'd0);
        check("t5b_err", 32'(r_err), 32'd0);

        // Reset pulsed in ACCESS
        s_hang = 1'b1;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h7;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        check("t6_in_access", {30'h0, psel, penable}, 32'h3);
        #2 presetn = 1'b0;
        #1;
        check("t6_async_psel", 32'(psel), 32'd0);
        check("t6_async_penable", 32'(penable), 32'd0);
        n_rst_rsp = 0;
        repeat (2) begin
            @(negedge pclk);
            if (rsp_valid) n_rst_rsp++;
        end
        presetn = 1'b1;
        s_hang = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            if (rsp_valid) n_rst_rsp++;
        end
        check("t6_no_rsp", 32'(n_rst_rsp), 32'd0);
        check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t6_ctrl_untouched", s_ctrl, 32'h33);
        run_cmd(1'b1, 32'h10, 32'h5);
        check("t6_lat", 32'(r_lat), 32'd2);
        check("t6_err", 32'(r_err), 32'd0);
        check("t6_slave_ctrl", s_ctrl, 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
APB requester that converts a simple single-outstanding command interface into APB3 SETUP/ACCESS transfers. It drives our APB peripherals, such as the sin-LUT slave: ctrl at 0x10, result at 0x14. It holds ACCESS through slave wait states, captures prdata and pslverr, and returns a one-cycle response pulse. A wait-state watchdog aborts transfers the slave never completes.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles without pready before abort; 0 disables the watchdog

Ports:
pclk  in  1  clock; all logic on rising edge
presetn  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  master idle, command accepted when cmd_valid && cmd_ready at pclk edge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr sampled, or timeout
rsp_timeout  out  1  watchdog abort
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pready  in  1  slave ready
pslverr  in  1  slave error
prdata  in  DATA_W  slave read data

Behaviour:
- Reset (async, presetn low):
  - state IDLE; psel, penable, pwrite, paddr, pwdata = 0.
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0; wait counter = 0.
  - cmd_ready = 1.
- All outputs are registered, except cmd_ready, which is the decode (state == IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready = 1. On accept at edge N:
  - latch cmd_addr into paddr; cmd_write into pwrite.
  - pwdata = cmd_wdata for writes, 0 for reads.
  - psel = 1, penable = 0 after edge N; go to SETUP.
- SETUP: lasts exactly one cycle. Set penable = 1 after edge N+1; go to ACCESS; clear wait counter.
- ACCESS: psel = penable = 1. paddr, pwrite and pwdata are held stable.
  - pready sampled 1:
    - rsp_rdata = prdata on reads, 0 on writes; rsp_err = pslverr; rsp_timeout = 0.
    - psel = penable = 0; go to RESP.
  - pready 0 and TIMEOUT != 0 and counter == TIMEOUT-1:
    - abort: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
    - psel = penable = 0; go to RESP.
  - otherwise: counter increments, saturating.
- RESP: rsp_valid = 1 for exactly one cycle; return to IDLE. The next accept is possible at the following edge.
- rsp_rdata, rsp_err and rsp_timeout hold their values until the next completion.
- pready and pslverr are ignored outside ACCESS.
- pslverr is used only when sampled together with pready.
- Minimum latency, zero-wait slave (pready driven high in the cycle penable is high): accept edge N, pready sampled edge N+2, rsp_valid high in cycle N+3.
- Registered-pready slave (e.g. the sin slave): one extra cycle; rsp_valid high in cycle N+4.
- Throughput: one transfer outstanding; cmd_ready is low in SETUP, ACCESS and RESP.
- Reset mid-transfer: psel and penable drop immediately. No rsp_valid is produced for the aborted command. The first command after reset release is handled normally.
- cmd_* changes while not accepted have no effect.

Decomposition:
- Shared package apb_pkg:
  - apb_mst_state_t enum (IDLE, SETUP, ACCESS, RESP).
  - register offset constants: SIN_CTRL_ADDR = 8'h10, SIN_OUT_ADDR = 8'h14.
  - error-data constant 32'hDEAD_BEEF.
- One sub-module, apb_wait_timer: a saturating counter with clear, enable and a terminal-count output compared against TIMEOUT. All other logic stays in apb_master_ctrl.

Test Plan:
1. Zero-wait slave model, write 0x10 data 0x2 → psel=1 cycle N+1, penable=1 cycle N+2, rsp_valid cycle N+3 with rsp_err=0 and rsp_rdata=0; slave ctrl reg = 0x2.
2. Follow-up read of 0x14 against the sin slave → rsp_valid cycle N+4, rsp_rdata = 0x00010000, rsp_err=0.
3. Read 0x20 from the sin slave → rsp_err=1, rsp_timeout=0, rsp_rdata = 0x0 (the slave's prdata).
4. Slave inserts 5 wait states → psel, penable, paddr and pwdata are stable for all 6 ACCESS cycles; exactly one rsp_valid follows.
5. TIMEOUT=16, slave never asserts pready → after 16 ACCESS cycles psel drops; rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0; cmd_ready=1 next cycle.
6. presetn pulsed low in ACCESS → psel and penable go 0 asynchronously, no rsp_valid; after release, a write to 0x10 completes normally.
